mem_read_ncl_encoder: RTL and testbench
=======================================

# mem_read_ncl_encoder

Clocked bridge that sits directly upstream of the memory data demultiplexer. It accepts read requests on a synchronous valid/ready port, reads one byte from a synchronous memory, and encodes the byte as dual-rail NCL DATA with a dual-rail PH0 destination select. It then runs the four-phase return-to-NULL handshake against the acknowledge of the selected destination (instruction or cache). This is the only point where the synchronous memory domain enters the asynchronous NCL datapath.

## Interface
- ADDR_W, 8, memory address width
- SYNC_STAGES, 2, flip-flop depth of each acknowledge synchronizer (≥2)
- TIMEOUT, 1023, cycles in a wait state before `err` sets

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  1  read request valid
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  byte address
- req_dest  in  1  0 = instruction, 1 = cache
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_rdata  in  8  read data, valid the cycle after `mem_rd_en`
- data_out  out  16  dual-rail byte; bit i true rail = [2i+1], false rail = [2i]
- PH0  out  2  dual-rail select; [1] true rail, [0] false rail
- ack_in_instr  in  1  async acknowledge from the instruction branch
- ack_in_cache  in  1  async acknowledge from the cache branch
- done  out  1  one-cycle pulse when a transfer completes (NULL acknowledged)
- err  out  1  sticky acknowledge-timeout flag

## Operation
- Encoding:
  - Bit value 1 is true-rail=1, false-rail=0.
  - Bit value 0 is true-rail=0, false-rail=1.
  - NULL is 00 on every pair.
  - PH0 = 2'b01 selects instruction; PH0 = 2'b10 selects cache.
  - The encoder never produces 11.
- FSM states: IDLE, READ, LOAD, WAIT_ACK, WAIT_NULL.
- IDLE:
  - `req_ready` = 1.
  - When `req_valid` is high, latch `req_addr` and `req_dest` and go to READ.
- READ:
  - `mem_rd_en` = 1 and `mem_addr` = latched address.
  - Go to LOAD.
- LOAD:
  - Register the encoded `mem_rdata` into `data_out` and the encoded destination into `PH0`, both on the same edge.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - Hold DATA.
  - When the synchronized ack of the latched destination is 1, drive `data_out` and `PH0` to all-zero (NULL) on the same edge and go to WAIT_NULL.
- WAIT_NULL:
  - Hold NULL.
  - When the synchronized ack of the latched destination is 0, pulse `done` and go to IDLE.
- Acknowledge handling:
  - Only the latched destination's ack is examined.
  - The other branch's ack is ignored throughout.
- Timeout:
  - A counter runs in WAIT_ACK and WAIT_NULL and clears on every state change.
  - When it reaches TIMEOUT, `err` sets and stays set until reset.
  - The FSM keeps waiting; it never abandons a handshake.
- All NCL-facing outputs come straight from flops, with no combinational decode after them.

## Timing
- Reset values:
  - `data_out` = 16'h0000 and `PH0` = 2'b00 (NULL).
  - `req_ready` = 1 (state IDLE).
  - `mem_rd_en`, `done`, `err` = 0.
  - Synchronizer flops = 0.
  - Timeout counter = 0.
- Request accepted at edge E0:
  - `mem_rd_en` is high during cycle E0–E1.
  - DATA appears on `data_out`/`PH0` after edge E2.
- From the selected ack rising to NULL being driven: SYNC_STAGES+1 edges.
- From the ack falling to `done`: SYNC_STAGES+1 edges; `req_ready` is high in the cycle after the `done` edge.
- Back-to-back requests: the next request can be accepted in the first IDLE cycle after `done`. There is no overlap, because a new DATA wave is never issued before NULL has been acknowledged.
- Ack already high at LOAD (stale): WAIT_ACK sees it and issues NULL. This is legal for a correctly reset NCL stage and is not an error.
- `req_valid` outside IDLE is ignored, and `req_addr`/`req_dest` are not sampled.
- Reset mid-transfer: on the reset edge, outputs go to NULL and the FSM goes to IDLE. The downstream stage shares `rst_n`, so the handshake restarts clean.

## Structure
- Package `ncl_pkg`:
  - NULL constant (16'h0000).
  - PH0 encodings: INSTR = 2'b01, CACHE = 2'b10.
  - Dual-rail encode function (8 → 16).
  - FSM state enum.
- Sub-module `ack_sync`: parameterized SYNC_STAGES flop chain with synchronous active-low reset, instantiated once per ack input.

## Test plan
- Reset, then request addr 8'h10 → instruction, memory returns 8'hA5:
  - `mem_rd_en` is high for exactly one cycle with `mem_addr` = 8'h10.
  - `data_out` = 16'h9966 and `PH0` = 2'b01 appear 2 edges after acceptance.
  - Raising `ack_in_instr` → all NULL after 3 edges.
  - Dropping it → `done` pulses.
- Request to cache with data 8'h00:
  - `data_out` = 16'h5555 and `PH0` = 2'b10.
  - Toggling `ack_in_instr` has no effect.
  - `ack_in_cache` completes the transfer.
- Data 8'hFF:
  - `data_out` = 16'hAAAA.
  - Two back-to-back requests with immediate acks: second acceptance occurs the cycle after the first `done`, and no output bit pair is ever 11.
- Ack held low for TIMEOUT cycles in WAIT_ACK:
  - `err` = 1 and stays 1.
  - A late ack still completes the transfer normally.
- `rst_n` asserted in WAIT_ACK:
  - After the next edge, `data_out` = 0, `PH0` = 0, `req_ready` = 1, `err` = 0.
  - A following transfer completes normally.

Source files
------------

// File: rtl/ncl_pkg.sv
// Shared NCL encodings, the dual-rail encode helper and the bridge FSM state type.
package ncl_pkg;

  localparam logic [15:0] NullData = 16'h0000;
  localparam logic [1:0]  NullPh0  = 2'b00;
  localparam logic [1:0]  Ph0Instr = 2'b01;
  localparam logic [1:0]  Ph0Cache = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StWaitAck,
    StWaitNull
  } state_e;

  // Bit i maps to rail pair {true=[2i+1], false=[2i]}; never yields 11.
  function automatic logic [15:0] ncl_encode(input logic [7:0] b);
    logic [15:0] w;
    w = NullData;
    for (int i = 0; i < 8; i++) begin
      w[2*i+1] = b[i];
      w[2*i]   = ~b[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/ack_sync.sv
// Flop chain bringing an asynchronous NCL acknowledge into the clock domain.
module ack_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  // Reset is synchronous so it lines up with the downstream NCL stage reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/mem_read_ncl_encoder.sv
// Reads a byte from synchronous memory and issues it as one dual-rail NCL DATA wave,
// then completes the return-to-NULL handshake with the selected destination.
module mem_read_ncl_encoder
  import ncl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_dest,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       data_out,
  output logic [1:0]        PH0,
  input  logic              ack_in_instr,
  input  logic              ack_in_cache,
  output logic              done,
  output logic              err
);

  localparam int unsigned   CntW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dest_q, dest_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        ph0_q, ph0_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic ack_instr_s, ack_cache_s, ack_sel;
  logic in_wait;

  ack_sync #(
    .Stages (SYNC_STAGES)
  ) u_sync_instr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (ack_in_instr),
    .q_o    (ack_instr_s)
  );

  ack_sync #(
    .Stages (SYNC_STAGES)
  ) u_sync_cache (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (ack_in_cache),
    .q_o    (ack_cache_s)
  );

  // Only the latched destination's acknowledge is ever looked at.
  assign ack_sel = dest_q ? ack_cache_s : ack_instr_s;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dest_d  = dest_q;
    data_d  = data_q;
    ph0_d   = ph0_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          dest_d  = req_dest;
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StLoad;
      end
      StLoad: begin
        data_d  = ncl_encode(mem_rdata);
        ph0_d   = dest_q ? Ph0Cache : Ph0Instr;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (ack_sel) begin
          data_d  = NullData;
          ph0_d   = NullPh0;
          state_d = StWaitNull;
        end
      end
      StWaitNull: begin
        if (!ack_sel) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        data_d  = NullData;
        ph0_d   = NullPh0;
        state_d = StIdle;
      end
    endcase
  end

  // Timeout counter only advances while parked in a wait state; it saturates so err
  // stays a pure flag and the handshake is never abandoned.
  assign in_wait = (state_q == StWaitAck || state_q == StWaitNull) && (state_d == state_q);

  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (in_wait) begin
      cnt_d = (cnt_q == TimeoutVal) ? cnt_q : cnt_q + 1'b1;
      if (cnt_d == TimeoutVal) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      dest_q  <= 1'b0;
      data_q  <= NullData;
      ph0_q   <= NullPh0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      ph0_q   <= ph0_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign mem_rd_en = (state_q == StRead);
  assign mem_addr  = addr_q;
  assign data_out  = data_q;
  assign PH0       = ph0_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_read_ncl_encoder.sv
// Directed, table-driven bench for the memory-to-NCL bridge.
module tb_mem_read_ncl_encoder;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 30;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_dest;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [15:0]       data_out;
  logic [1:0]        PH0;
  logic              ack_in_instr;
  logic              ack_in_cache;
  logic              done;
  logic              err;

  logic man_instr, man_cache, auto_ack, auto_instr;
  logic [7:0] mem_arr [256];
  int n_total = 0;
  int n_pass  = 0;
  int bad_pairs = 0;

  always #5 clk = ~clk;

  mem_read_ncl_encoder #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_dest     (req_dest),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .data_out     (data_out),
    .PH0          (PH0),
    .ack_in_instr (ack_in_instr),
    .ack_in_cache (ack_in_cache),
    .done         (done),
    .err          (err)
  );

  // Synchronous memory: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_arr[mem_addr];
  end

  // Immediate-acknowledge responder for the back-to-back sequence.
  always @(posedge clk) auto_instr <= (PH0 != 2'b00);
  assign ack_in_instr = auto_ack ? auto_instr : man_instr;
  assign ack_in_cache = man_cache;

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (data_out[2*i+1] && data_out[2*i]) bad_pairs++;
    end
    if (PH0 == 2'b11) bad_pairs++;
  end

  typedef struct {
    logic [7:0]  addr;
    logic        dest;
    logic [7:0]  rdata;
    logic [15:0] exp_data;
    logic [1:0]  exp_ph0;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Issue a request at the next edge and check the read strobe and DATA arrival.
  task automatic start_req(input vec_t v);
    mem_arr[v.addr] = v.rdata;
    chk("ready_before_req", {15'd0, req_ready}, 16'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_dest  = v.dest;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = ~v.addr;
    req_dest  = ~v.dest;
    @(negedge clk);
    chk("rd_en_read", {15'd0, mem_rd_en}, 16'd1);
    chk("mem_addr", {8'd0, mem_addr}, {8'd0, v.addr});
    req_valid = 1'b1;  // must be ignored outside IDLE
    @(negedge clk);
    chk("rd_en_one_cycle", {15'd0, mem_rd_en}, 16'd0);
    chk("null_in_load", data_out, 16'h0000);
    @(negedge clk);
    req_valid = 1'b0;
    chk("data_out", data_out, v.exp_data);
    chk("ph0", {14'd0, PH0}, {14'd0, v.exp_ph0});
  endtask

  task automatic set_ack(input logic dest, input logic val);
    if (dest) man_cache = val;
    else man_instr = val;
  endtask

  // Four-phase completion with exact edge counts; called at a negedge.
  task automatic finish_req(input vec_t v);
    set_ack(v.dest, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("data_held_pre_null", data_out, v.exp_data);
    @(negedge clk);
    chk("null_data", data_out, 16'h0000);
    chk("null_ph0", {14'd0, PH0}, 16'd0);
    set_ack(v.dest, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("done_not_early", {15'd0, done}, 16'd0);
    @(negedge clk);
    chk("done_pulse", {15'd0, done}, 16'd1);
    chk("ready_after_done", {15'd0, req_ready}, 16'd1);
    @(negedge clk);
    chk("done_one_cycle", {15'd0, done}, 16'd0);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(name, {15'd0, done}, 16'd1);
  endtask

  initial begin
    vecs[0] = '{addr: 8'h10, dest: 1'b0, rdata: 8'hA5, exp_data: 16'h9966, exp_ph0: 2'b01};
    vecs[1] = '{addr: 8'h20, dest: 1'b1, rdata: 8'h00, exp_data: 16'h5555, exp_ph0: 2'b10};
    vecs[2] = '{addr: 8'h30, dest: 1'b0, rdata: 8'hFF, exp_data: 16'hAAAA, exp_ph0: 2'b01};
    vecs[3] = '{addr: 8'h31, dest: 1'b1, rdata: 8'h3C, exp_data: 16'h5AA5, exp_ph0: 2'b10};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_dest = 1'b0;
    man_instr = 1'b0;
    man_cache = 1'b0;
    auto_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 16'h0000);
    chk("rst_ph0", {14'd0, PH0}, 16'd0);
    chk("rst_ready", {15'd0, req_ready}, 16'd1);
    chk("rst_rd_en", {15'd0, mem_rd_en}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      start_req(vecs[i]);
      // Wrong-branch ack must not disturb the held DATA.
      set_ack(~vecs[i].dest, 1'b1);
      repeat (5) @(negedge clk);
      chk("other_ack_ignored", data_out, vecs[i].exp_data);
      set_ack(~vecs[i].dest, 1'b0);
      repeat (4) @(negedge clk);
      finish_req(vecs[i]);
    end

    // Back-to-back requests with an immediate responder on the instruction branch.
    mem_arr[8'h40] = 8'hFF;
    mem_arr[8'h41] = 8'h0F;
    auto_ack = 1'b1;
    req_valid = 1'b1;
    req_addr = 8'h40;
    req_dest = 1'b0;
    wait_done("b2b_first_done");
    chk("b2b_ready_at_done", {15'd0, req_ready}, 16'd1);
    req_addr = 8'h41;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_accept", {15'd0, mem_rd_en}, 16'd1);
    chk("b2b_second_addr", {8'd0, mem_addr}, 16'h0041);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_second_data", data_out, 16'h55AA);
    wait_done("b2b_second_done");
    auto_ack = 1'b0;
    @(negedge clk);

    // Acknowledge timeout: err sets, then a late ack still completes.
    start_req(vecs[0]);
    repeat (TIMEOUT - 2) @(negedge clk);
    chk("err_not_early", {15'd0, err}, 16'd0);
    repeat (3) @(negedge clk);
    chk("err_set", {15'd0, err}, 16'd1);
    chk("data_held_timeout", data_out, vecs[0].exp_data);
    finish_req(vecs[0]);
    chk("err_sticky", {15'd0, err}, 16'd1);

    // Reset in WAIT_ACK returns everything to NULL/IDLE and clears err.
    start_req(vecs[1]);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_data", data_out, 16'h0000);
    chk("midrst_ph0", {14'd0, PH0}, 16'd0);
    chk("midrst_ready", {15'd0, req_ready}, 16'd1);
    chk("midrst_err", {15'd0, err}, 16'd0);
    start_req(vecs[3]);
    finish_req(vecs[3]);

    chk("no_11_pairs", 16'(bad_pairs), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
